// File: rtl/exc_pkg.sv
// Shared definitions for the exception unit: FSM state encoding and one-hot exception codes.
package exc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } exc_state_e;

  localparam logic [3:0] EXC_NONE  = 4'b0000;
  localparam logic [3:0] EXC_STACK = 4'b0001;
  localparam logic [3:0] EXC_MEM   = 4'b0010;
  localparam logic [3:0] EXC_IRQ   = 4'b0100;
  localparam logic [3:0] EXC_DBL   = 4'b1000;

endpackage

// File: rtl/exc_irq_latch.sv
// Interrupt edge detector: registers irq, flags a rising edge and holds it pending until taken.
module exc_irq_latch (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic irq_i,
  input  logic take_i,
  output logic pending_o
);

  logic irq_q;
  logic armed_q;
  logic pending_q;
  logic pending_d;
  logic irq_edge;

  // armed_q masks the first cycle after reset so a level already high at release is not an edge.
  assign irq_edge  = irq_i & ~irq_q & armed_q;
  assign pending_d = take_i ? 1'b0 : (pending_q | irq_edge);
  assign pending_o = pending_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q     <= 1'b0;
      armed_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      irq_q     <= irq_i;
      armed_q   <= 1'b1;
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/exception_unit.sv
// Prioritises MEM-stage faults and interrupts, captures EPC and sequences the flush window.
// Optional cause/count logging is enabled by defining EXC_CAUSE_LOG_EN.
module exception_unit
  import exc_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int HOLD_CYC = 2,
  parameter int CNT_W    = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            mem_err_i,
  input  logic            stack_err_i,
  input  logic            irq_i,
  input  logic [PC_W-1:0] pc_mem_i,
  input  logic [PC_W-1:0] pc_dec_i,
  output logic [3:0]      exceptions_o,
  output logic [PC_W-1:0] epc_o,
  output logic            epc_we_o,
  output logic            irq_ack_o,
  output logic            busy_o
`ifdef EXC_CAUSE_LOG_EN
  ,
  input  logic             cause_clr_i,
  output logic [3:0]       cause_o,
  output logic [CNT_W-1:0] exc_cnt_o
`endif
);

  localparam int HC_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HC_W-1:0] HOLD_INIT = HC_W'(HOLD_CYC - 1);

  exc_state_e      state_q, state_d;
  logic [HC_W-1:0] cnt_q, cnt_d;
  logic [3:0]      exc_q, exc_d;
  logic [PC_W-1:0] epc_q, epc_d;
  logic            epc_we_q, epc_we_d;
  logic            irq_ack_q, irq_ack_d;
  logic            irq_pending;
  logic            take_irq;
  logic            fault;

  assign fault = mem_err_i | stack_err_i;

  exc_irq_latch u_irq_latch (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .irq_i     (irq_i),
    .take_i    (take_irq),
    .pending_o (irq_pending)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    exc_d     = exc_q;
    epc_d     = epc_q;
    epc_we_d  = 1'b0;
    irq_ack_d = 1'b0;
    take_irq  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fault || irq_pending) begin
          epc_we_d = 1'b1;
          cnt_d    = HOLD_INIT;
          state_d  = ST_HOLD;
          // Errors outrank the interrupt; a losing irq simply stays pending.
          if (mem_err_i) begin
            exc_d = EXC_MEM;
            epc_d = pc_mem_i;
          end else if (stack_err_i) begin
            exc_d = EXC_STACK;
            epc_d = pc_mem_i;
          end else begin
            exc_d     = EXC_IRQ;
            epc_d     = pc_dec_i;
            irq_ack_d = 1'b1;
            take_irq  = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (fault) begin
          exc_d   = EXC_DBL;
          state_d = ST_HALT;
        end else if (cnt_q == '0) begin
          exc_d   = EXC_NONE;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DRAIN: begin
        if (fault) begin
          exc_d   = EXC_DBL;
          state_d = ST_HALT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      exc_q     <= EXC_NONE;
      epc_q     <= '0;
      epc_we_q  <= 1'b0;
      irq_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      exc_q     <= exc_d;
      epc_q     <= epc_d;
      epc_we_q  <= epc_we_d;
      irq_ack_q <= irq_ack_d;
    end
  end

  assign exceptions_o = exc_q;
  assign epc_o        = epc_q;
  assign epc_we_o     = epc_we_q;
  assign irq_ack_o    = irq_ack_q;
  assign busy_o       = (state_q != ST_IDLE);

`ifdef EXC_CAUSE_LOG_EN
  logic [3:0]       cause_q, cause_d;
  logic [CNT_W-1:0] exc_cnt_q, exc_cnt_d;
  logic             log_evt;

  // An event taken in the same cycle as a clear takes precedence over the clear.
  assign log_evt = ((state_q == ST_IDLE) && (state_d == ST_HOLD)) ||
                   ((state_q != ST_HALT) && (state_d == ST_HALT));

  always_comb begin
    cause_d   = cause_q;
    exc_cnt_d = exc_cnt_q;
    if (log_evt) begin
      cause_d = cause_q | exc_d;
      if (exc_cnt_q != '1) exc_cnt_d = exc_cnt_q + CNT_W'(1);
    end else if (cause_clr_i) begin
      cause_d   = '0;
      exc_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cause_q   <= '0;
      exc_cnt_q <= '0;
    end else begin
      cause_q   <= cause_d;
      exc_cnt_q <= exc_cnt_d;
    end
  end

  assign cause_o   = cause_q;
  assign exc_cnt_o = exc_cnt_q;
`endif

endmodule

// File: tb/tb_exception_unit.sv
// Scoreboard bench for exception_unit: stimulus pushes expected events, a negedge monitor checks them.
module tb_exception_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        mem_err_i, stack_err_i, irq_i;
  logic [31:0] pc_mem_i, pc_dec_i;
  logic [3:0]  exceptions_o;
  logic [31:0] epc_o;
  logic        epc_we_o, irq_ack_o, busy_o;
`ifdef EXC_CAUSE_LOG_EN
  logic        cause_clr_i;
  logic [3:0]  cause_o;
  logic [7:0]  exc_cnt_o;
`endif

  typedef struct packed {
    logic [3:0]  exc;
    logic [31:0] epc;
    logic        we;
    logic        ack;
  } exp_t;

  exp_t       sb_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         ack_cnt = 0;
  logic [3:0] prev_exc = 4'b0;

  exception_unit #(.PC_W(32), .HOLD_CYC(2), .CNT_W(8)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .mem_err_i    (mem_err_i),
    .stack_err_i  (stack_err_i),
    .irq_i        (irq_i),
    .pc_mem_i     (pc_mem_i),
    .pc_dec_i     (pc_dec_i),
    .exceptions_o (exceptions_o),
    .epc_o        (epc_o),
    .epc_we_o     (epc_we_o),
    .irq_ack_o    (irq_ack_o),
    .busy_o       (busy_o)
`ifdef EXC_CAUSE_LOG_EN
    ,
    .cause_clr_i  (cause_clr_i),
    .cause_o      (cause_o),
    .exc_cnt_o    (exc_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Monitor: an output event is a new non-zero exceptions value or any epc_we/irq_ack pulse.
  always @(negedge clk_i) begin
    exp_t e;
    if ((exceptions_o != prev_exc && exceptions_o != 4'b0) || epc_we_o || irq_ack_o) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got exc=%b epc=%h we=%b ack=%b, required no event",
                 exceptions_o, epc_o, epc_we_o, irq_ack_o);
      end else begin
        e = sb_q.pop_front();
        if (exceptions_o !== e.exc || epc_o !== e.epc || epc_we_o !== e.we || irq_ack_o !== e.ack) begin
          n_fail++;
          $display("FAIL sb_event: got exc=%b epc=%h we=%b ack=%b, required exc=%b epc=%h we=%b ack=%b",
                   exceptions_o, epc_o, epc_we_o, irq_ack_o, e.exc, e.epc, e.we, e.ack);
        end else begin
          $display("txn exc=%b epc=%h we=%b ack=%b ok", exceptions_o, epc_o, epc_we_o, irq_ack_o);
        end
      end
    end
    if (irq_ack_o) ack_cnt++;
    prev_exc = exceptions_o;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] exc, input logic [31:0] epc, input logic we, input logic ack);
    exp_t e;
    e.exc = exc; e.epc = epc; e.we = we; e.ack = ack;
    sb_q.push_back(e);
  endtask

  initial begin
    rst_ni = 1'b1;
    mem_err_i = 1'b0; stack_err_i = 1'b0; irq_i = 1'b0;
    pc_mem_i = 32'h0; pc_dec_i = 32'h0;
`ifdef EXC_CAUSE_LOG_EN
    cause_clr_i = 1'b0;
`endif
    #2 rst_ni = 1'b0;
    tick(); tick();
    chk("rst_exc", {28'h0, exceptions_o}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_epc", epc_o, 32'h0);
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_exc", {28'h0, exceptions_o}, 32'h0);
      chk("idle_busy", {31'h0, busy_o}, 32'h0);
      chk("idle_epc", epc_o, 32'h0);
    end

    // Single mem_err: two cycles of 0010, one DRAIN, then idle.
    mem_err_i = 1'b1; pc_mem_i = 32'h40;
    push(4'b0010, 32'h40, 1'b1, 1'b0);
    tick();
    mem_err_i = 1'b0;
    chk("mem_exc1", {28'h0, exceptions_o}, 32'h2);
    chk("mem_busy1", {31'h0, busy_o}, 32'h1);
    tick();
    chk("mem_exc2", {28'h0, exceptions_o}, 32'h2);
    tick();
    chk("mem_drain_exc", {28'h0, exceptions_o}, 32'h0);
    chk("mem_drain_busy", {31'h0, busy_o}, 32'h1);
    tick();
    chk("mem_idle_busy", {31'h0, busy_o}, 32'h0);

    // irq rises during a stack_err HOLD and is taken on the first IDLE cycle.
    stack_err_i = 1'b1; pc_mem_i = 32'h60;
    push(4'b0001, 32'h60, 1'b1, 1'b0);
    push(4'b0100, 32'h88, 1'b1, 1'b1);
    tick();
    stack_err_i = 1'b0; irq_i = 1'b1; pc_dec_i = 32'h88;
    tick(); tick(); tick();
    chk("irq_wait_exc", {28'h0, exceptions_o}, 32'h0);
    tick();
    chk("irq_exc", {28'h0, exceptions_o}, 32'h4);
    chk("irq_epc", epc_o, 32'h88);
    repeat (5) tick();
    chk("irq_held_busy", {31'h0, busy_o}, 32'h0);
    irq_i = 1'b0;
    tick();

    // mem_err and stack_err together: mem wins, stack dropped.
`ifdef EXC_CAUSE_LOG_EN
    cause_clr_i = 1'b1;
    tick();
    cause_clr_i = 1'b0;
`endif
    mem_err_i = 1'b1; stack_err_i = 1'b1; pc_mem_i = 32'hA0;
    push(4'b0010, 32'hA0, 1'b1, 1'b0);
    tick();
    mem_err_i = 1'b0; stack_err_i = 1'b0;
    repeat (4) tick();
    chk("both_busy", {31'h0, busy_o}, 32'h0);
`ifdef EXC_CAUSE_LOG_EN
    chk("both_cause", {28'h0, cause_o}, 32'h2);
    chk("both_cnt", {24'h0, exc_cnt_o}, 32'h1);
`endif

    // Error and irq edge together: error first, irq follows after DRAIN.
    mem_err_i = 1'b1; pc_mem_i = 32'hB0; irq_i = 1'b1; pc_dec_i = 32'hC0;
    push(4'b0010, 32'hB0, 1'b1, 1'b0);
    push(4'b0100, 32'hC0, 1'b1, 1'b1);
    tick();
    mem_err_i = 1'b0;
    repeat (8) tick();
    chk("err_irq_busy", {31'h0, busy_o}, 32'h0);
    irq_i = 1'b0;
    tick();

    // Double fault: stack_err during HOLD of a mem_err locks up in HALT.
    mem_err_i = 1'b1; pc_mem_i = 32'hD0;
    push(4'b0010, 32'hD0, 1'b1, 1'b0);
    tick();
    mem_err_i = 1'b0; stack_err_i = 1'b1; pc_mem_i = 32'hE0;
    push(4'b1000, 32'hD0, 1'b0, 1'b0);
    tick();
    stack_err_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      irq_i = (i == 3);
      mem_err_i = (i == 8);
      tick();
      chk("halt_exc", {28'h0, exceptions_o}, 32'h8);
      chk("halt_busy", {31'h0, busy_o}, 32'h1);
      chk("halt_epc", epc_o, 32'hD0);
    end
    irq_i = 1'b0; mem_err_i = 1'b0;
`ifdef EXC_CAUSE_LOG_EN
    chk("halt_cause", {28'h0, cause_o}, 32'hE);
    chk("halt_cnt", {24'h0, exc_cnt_o}, 32'h5);
`endif
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick(); tick();

    // Reset mid-HOLD with an irq pending; the still-high level must not retrigger.
    mem_err_i = 1'b1; pc_mem_i = 32'hF0; irq_i = 1'b1; pc_dec_i = 32'h12;
    push(4'b0010, 32'hF0, 1'b1, 1'b0);
    tick();
    mem_err_i = 1'b0;
    @(negedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    chk("midrst_exc", {28'h0, exceptions_o}, 32'h0);
    chk("midrst_busy", {31'h0, busy_o}, 32'h0);
    chk("midrst_epc", epc_o, 32'h0);
    chk("midrst_we", {31'h0, epc_we_o}, 32'h0);
    tick(); tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_rst_exc", {28'h0, exceptions_o}, 32'h0);
      chk("post_rst_busy", {31'h0, busy_o}, 32'h0);
    end
    irq_i = 1'b0;
    repeat (2) tick();

    chk("sb_empty", sb_q.size(), 32'h0);
    chk("irq_ack_count", ack_cnt, 32'h2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
